// File: rtl/local_mult_pkg.sv
// local_mult_pipe shared definitions.
// Width derivation helpers and pipeline depth limits.
package local_mult_pkg;

    localparam int PIPE_MIN = 1;
    localparam int PIPE_MAX = 4;

    // Wide enough for a 64x64 product plus two extension bits.
    localparam int MAXW = 130;

    typedef logic signed [MAXW-1:0] wide_t;

    function automatic int full_width(int wa, int wb);
        return wa + wb + 2;
    endfunction

    function automatic wide_t smax(int w);
        wide_t one;
        one = 1;
        return (one <<< (w - 1)) - 1;
    endfunction

    function automatic wide_t smin(int w);
        wide_t one;
        one = 1;
        return -(one <<< (w - 1));
    endfunction

    function automatic wide_t umax(int w);
        wide_t one;
        one = 1;
        return (one <<< w) - 1;
    endfunction

endpackage

// File: rtl/local_mult_if.sv
// local_mult_pipe operand/result handshake bundle.
// master drives operands and out_ready; slave is the multiplier.
interface local_mult_if #(
    parameter int WA = 32,
    parameter int WB = 32,
    parameter int WP = 64,
    parameter int TW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [WA-1:0] dataa;
    logic [WB-1:0] datab;
    logic          signa;
    logic          signb;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [WP-1:0] result;
    logic [TW-1:0] out_tag;
    logic          overflow;

    modport master (
        output in_valid, dataa, datab,
        output signa, signb, in_tag,
        output out_ready,
        input  in_ready, out_valid,
        input  result, out_tag, overflow
    );

    modport slave (
        input  in_valid, dataa, datab,
        input  signa, signb, in_tag,
        input  out_ready,
        output in_ready, out_valid,
        output result, out_tag, overflow
    );
endinterface

// File: rtl/local_mult_stage.sv
// One local_mult_pipe register stage: valid, tag and data.
// Moves only on advance; asynchronously cleared.
module local_mult_stage #(
    parameter int DW = 8,
    parameter int TW = 4
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          advance,
    input  logic          d_valid,
    input  logic [TW-1:0] d_tag,
    input  logic [DW-1:0] d_data,
    output logic          q_valid,
    output logic [TW-1:0] q_tag,
    output logic [DW-1:0] q_data
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q_valid <= 1'b0;
            q_tag   <= '0;
            q_data  <= '0;
        end else if (advance) begin
            q_valid <= d_valid;
            q_tag   <= d_tag;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/local_mult_pipe.sv
// Pipelined signed/unsigned multiplier with tag and valid/ready flow.
// LOCAL_MULT_SAT_EN: clamp narrow results and flag overflow.
module local_mult_pipe
    import local_mult_pkg::*;
#(
    parameter int LPA_WIDTHA   = 32,
    parameter int LPA_WIDTHB   = 32,
    parameter int LPA_WIDTHP   = 64,
    parameter int LPA_PIPELINE = 2,
    parameter int LPA_TAGW     = 4
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          clken,
    local_mult_if.slave   bus
);

    localparam int FW = full_width(LPA_WIDTHA, LPA_WIDTHB);
    localparam int NS =
        (LPA_PIPELINE < PIPE_MIN) ? PIPE_MIN :
        (LPA_PIPELINE > PIPE_MAX) ? PIPE_MAX :
        LPA_PIPELINE;
    localparam int DW = LPA_WIDTHP + 1;

    logic                     advance;
    logic signed [LPA_WIDTHA:0] ax;
    logic signed [LPA_WIDTHB:0] bx;
    logic signed [FW-1:0]     ae;
    logic signed [FW-1:0]     be;
    logic signed [FW-1:0]     prod;
    logic [LPA_WIDTHP-1:0]    res_d;
    logic                     ovf_d;

    // The output register counts as a full slot: a held result
    // blocks the whole pipe, so bubbles are never collapsed.
    assign advance      = clken & (~bus.out_valid | bus.out_ready);
    assign bus.in_ready = advance;

    assign ax = {bus.signa & bus.dataa[LPA_WIDTHA-1], bus.dataa};
    assign bx = {bus.signb & bus.datab[LPA_WIDTHB-1], bus.datab};
    assign ae = FW'(ax);
    assign be = FW'(bx);
    assign prod = ae * be;

`ifdef LOCAL_MULT_SAT_EN
    localparam wide_t SMAX = smax(LPA_WIDTHP);
    localparam wide_t SMIN = smin(LPA_WIDTHP);
    localparam wide_t UMAX = umax(LPA_WIDTHP);

    wide_t pw;

    assign pw = wide_t'(prod);

    always_comb begin
        res_d = LPA_WIDTHP'(prod);
        ovf_d = 1'b0;
        if (LPA_WIDTHP < FW) begin
            if (bus.signa | bus.signb) begin
                if (pw > SMAX) begin
                    res_d = SMAX[LPA_WIDTHP-1:0];
                    ovf_d = 1'b1;
                end else if (pw < SMIN) begin
                    res_d = SMIN[LPA_WIDTHP-1:0];
                    ovf_d = 1'b1;
                end
            end else if (pw > UMAX) begin
                res_d = UMAX[LPA_WIDTHP-1:0];
                ovf_d = 1'b1;
            end
        end
    end
`else
    // Signed cast sign-extends a wide result and wraps a narrow one.
    assign res_d = LPA_WIDTHP'(prod);
    assign ovf_d = 1'b0;
`endif

    logic                v [0:NS];
    logic [LPA_TAGW-1:0] t [0:NS];
    logic [DW-1:0]       d [0:NS];

    assign v[0] = bus.in_valid;
    assign t[0] = bus.in_tag;
    assign d[0] = {ovf_d, res_d};

    for (genvar i = 0; i < NS; i++) begin : g_stage
        local_mult_stage #(
            .DW (DW),
            .TW (LPA_TAGW)
        ) u_stage (
            .clock   (clock),
            .resetn  (resetn),
            .advance (advance),
            .d_valid (v[i]),
            .d_tag   (t[i]),
            .d_data  (d[i]),
            .q_valid (v[i+1]),
            .q_tag   (t[i+1]),
            .q_data  (d[i+1])
        );
    end

    assign bus.out_valid = v[NS];
    assign bus.out_tag   = t[NS];
    assign bus.result    = d[NS][LPA_WIDTHP-1:0];
    assign bus.overflow  = d[NS][LPA_WIDTHP];

endmodule

// File: doc/local_mult_pipe.md
LOCAL_MULT_PIPE -- requirements
Module: local_mult_pipe

Interface
- REQ-001: Parameter LPA_WIDTHA, default 32, operand A width (2..64).
- REQ-002: Parameter LPA_WIDTHB, default 32, operand B width (2..64).
- REQ-003: Parameter LPA_WIDTHP, default 64, result width (2..128); may be less than, equal to, or greater than LPA_WIDTHA+LPA_WIDTHB.
- REQ-004: Parameter LPA_PIPELINE, default 2, register stages from input to result (1..4).
- REQ-005: Parameter LPA_TAGW, default 4, sideband tag width carried alongside each product.
- REQ-006: clock  in  1  sole clock; all flops on its rising edge; no gated clocks.
- REQ-007: resetn  in  1  asynchronous, active-low reset.
- REQ-008: clken  in  1  global advance enable; low freezes all state.
- REQ-009: in_valid  in  1  operands presented.
- REQ-010: in_ready  out  1  block accepts operands this cycle.
- REQ-011: dataa  in  LPA_WIDTHA  operand A.
- REQ-012: datab  in  LPA_WIDTHB  operand B.
- REQ-013: signa / signb  in  1 each  per-operation signedness of A / B (1 = two's complement).
- REQ-014: in_tag  in  LPA_TAGW  sideband tag.
- REQ-015: out_valid  out  1  result holds a product.
- REQ-016: out_ready  in  1  consumer accepts result.
- REQ-017: result  out  LPA_WIDTHP  product.
- REQ-018: out_tag  out  LPA_TAGW  tag of the product on result.
- REQ-019: overflow  out  1  product did not fit LPA_WIDTHP (meaningful only with LOCAL_MULT_SAT_EN; else tied 0).

Function
- REQ-020: advance = clken & (~out_valid | out_ready); in_ready SHALL equal advance combinationally.
- REQ-021: Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
- REQ-022: Each operand SHALL be extended by one bit (sign-extend if its sign bit set, else zero-extend) and multiplied exactly, giving a signed (LPA_WIDTHA+LPA_WIDTHB+2)-bit product; mixed signedness legal.
- REQ-023: When LPA_WIDTHP >= full width, result SHALL be the exact product sign-extended if signa|signb, else zero-extended.
- REQ-024: When LPA_WIDTHP < full width and saturation compiled out, result SHALL be the low LPA_WIDTHP bits.
- REQ-025: Latency SHALL be exactly LPA_PIPELINE cycles of advance from input transfer to out_valid; with advance held high, throughput one product per cycle.
- REQ-026: All stages, valid bits and tags SHALL move only when advance is 1; bubbles are not collapsed.
- REQ-027: While out_valid & ~out_ready, result, out_tag and overflow SHALL stay stable.
- REQ-028: Simultaneous output transfer and input transfer in the same cycle SHALL be lossless.
- REQ-029: in_valid low during advance SHALL inject a bubble (valid 0); operand values of bubbles are don't-care.

Reset
- REQ-030: resetn low SHALL asynchronously clear all stage valid bits, out_valid, result, out_tag, overflow to 0; in-flight products are discarded.
- REQ-031: First input transfer after reset deassertion SHALL be possible on the first rising edge with resetn high.

Configuration
- REQ-032: With LOCAL_MULT_SAT_EN defined and LPA_WIDTHP < full width, out-of-range products SHALL clamp to max/min of the result type (signed if signa|signb, else unsigned) and overflow SHALL be 1 for that product; without it, wrap per REQ-024 and overflow is constant 0.

Structure
- REQ-033: Package local_mult_pkg SHALL hold width-derivation functions (full product width, signed/unsigned max/min) and the LPA_PIPELINE limits.
- REQ-034: One sub-module local_mult_stage (valid+tag+data register with advance enable and async active-low clear) SHALL be instantiated per pipeline stage.

Verification (A=B=8, P=16, PIPELINE=2 unless stated)
- REQ-035: 0xFF*0xFF, signa=signb=0 -> result 0xFE01 two cycles later; signa=signb=1 -> 0x0001; signa=1,signb=0 -> 0xFF01.
- REQ-036: Back-to-back 10 products, out_ready=1 -> 10 consecutive out_valid cycles, tags in order, no gaps.
- REQ-037: out_ready=0 for 3 cycles while out_valid -> result/out_tag frozen, in_ready=0, no loss after release.
- REQ-038: P=8, 16*16 unsigned -> 0x00 overflow 0 without macro; 0xFF overflow 1 with LOCAL_MULT_SAT_EN; signed -128*-128 -> 0x7F overflow 1 with macro.
- REQ-039: resetn low with 2 products in flight -> out_valid 0 immediately, result 0; no stale product emerges after release.
- REQ-040: clken=0 for 4 cycles mid-stream -> all state frozen, in_ready=0; stream resumes unchanged.
